// File: rtl/lane_car_gen.sv
// Per-pixel car generator for horizontally scrolling traffic lanes plus per-frame player collision flag.
// Optional define HIT_COUNT_EN adds a saturating count of frames that contained a collision.
module lane_car_gen #(
    parameter int NUM_LANES       = 4,
    parameter int LANE_Y0         = 96,
    parameter int LANE_H          = 48,
    parameter int CAR_INSET       = 8,
    parameter int CAR_W           = 48,
    parameter int CAR_PERIOD_LOG2 = 7,
    parameter int LANE_PHASE      = 40,
    parameter int PLAYER_SZ       = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] scroll_x,
    input  logic [9:0] pix_x,
    input  logic [9:0] pix_y,
    input  logic       video_active,
    input  logic       frame_start,
    input  logic [9:0] player_x,
    input  logic [9:0] player_y,
    output logic       car_on,
    output logic [1:0] lane_idx,
    output logic       hit,
    output logic [7:0] hit_count
);

    typedef enum logic {WAIT_FRAME, SCAN} state_t;

    state_t state;
    logic   acc;
    logic [9:0] scroll_q;

    logic [9:0]  rel, roff;
    logic [1:0]  lane_c;
    logic        in_lane_c, row_ok_c, ply_c;
    logic [10:0] phase, sum;

    logic                       va_d1, in_lane_d1, row_ok_d1, ply_d1, ply_d2;
    logic [1:0]                 lane_d1;
    logic [CAR_PERIOD_LOG2-1:0] eff_d1;
    logic                       car_c, acc_next;

    // NOTE: every variable gets a default at the top of always_comb so no latch is inferred.
    always_comb begin
        rel       = pix_y - 10'(LANE_Y0);
        in_lane_c = (pix_y >= 10'(LANE_Y0)) && (rel < 10'(NUM_LANES * LANE_H));
        lane_c    = '0;
        roff      = rel;
        for (int i = 1; i < NUM_LANES; i++) begin
            if (rel >= 10'(i * LANE_H)) begin
                lane_c = 2'(i);
                roff   = rel - 10'(i * LANE_H);
            end
        end
        row_ok_c = (roff >= 10'(CAR_INSET)) && (roff <= 10'(CAR_INSET + 31));

        // Even lanes scroll right, odd lanes left; sum stays below 3*640 so two folds suffice.
        phase = 11'(lane_c) * 11'(LANE_PHASE);
        if (!lane_c[0])
            sum = {1'b0, pix_x} + 11'd640 - {1'b0, scroll_q} + phase;
        else
            sum = {1'b0, pix_x} + {1'b0, scroll_q} + phase;
        if (sum >= 11'd640) sum = sum - 11'd640;
        if (sum >= 11'd640) sum = sum - 11'd640;

        ply_c = ({1'b0, pix_x} >= {1'b0, player_x}) &&
                ({1'b0, pix_x} <  {1'b0, player_x} + 11'(PLAYER_SZ)) &&
                ({1'b0, pix_y} >= {1'b0, player_y}) &&
                ({1'b0, pix_y} <  {1'b0, player_y} + 11'(PLAYER_SZ));
    end

    assign car_c    = va_d1 & in_lane_d1 & row_ok_d1 &
                      (eff_d1 < CAR_PERIOD_LOG2'(CAR_W));
    assign acc_next = acc | (car_on & ply_d2);

    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_q   <= '0;
            va_d1      <= 1'b0;
            in_lane_d1 <= 1'b0;
            row_ok_d1  <= 1'b0;
            lane_d1    <= '0;
            eff_d1     <= '0;
            ply_d1     <= 1'b0;
            ply_d2     <= 1'b0;
            car_on     <= 1'b0;
            lane_idx   <= '0;
        end else begin
            if (frame_start) scroll_q <= scroll_x;
            va_d1      <= video_active;
            in_lane_d1 <= in_lane_c;
            row_ok_d1  <= row_ok_c;
            lane_d1    <= lane_c;
            eff_d1     <= sum[CAR_PERIOD_LOG2-1:0];
            ply_d1     <= ply_c;
            ply_d2     <= ply_d1;
            car_on     <= car_c;
            lane_idx   <= car_c ? lane_d1 : 2'd0;
        end
    end

    // Collision accumulator; an overlap in the frame_start cycle still belongs to the closing frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= WAIT_FRAME;
            acc   <= 1'b0;
            hit   <= 1'b0;
        end else begin
            case (state)
                WAIT_FRAME: begin
                    acc <= 1'b0;
                    if (frame_start) state <= SCAN;
                end
                SCAN: begin
                    if (frame_start) begin
                        hit <= acc_next;
                        acc <= 1'b0;
                    end else begin
                        acc <= acc_next;
                    end
                end
                default: state <= WAIT_FRAME;
            endcase
        end
    end

`ifdef HIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (reset)
            hit_count <= '0;
        else if (state == SCAN && frame_start && acc_next && hit_count != 8'hFF)
            hit_count <= hit_count + 8'd1;
    end
`else
    assign hit_count = '0;
`endif

endmodule

// File: tb/tb_lane_car_gen.sv
// Randomized + directed bench for lane_car_gen against a per-pixel arithmetic model and a per-frame hit model.
module tb_lane_car_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] scroll_x, pix_x, pix_y, player_x, player_y;
    logic       video_active, frame_start;
    logic       car_on, hit;
    logic [1:0] lane_idx;
    logic [7:0] hit_count;

`ifdef HIT_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    // model state
    int msq, pend, exp_hit, exp_cnt, ply_x, ply_y;
    bit started, facc;

    lane_car_gen dut (
        .clk(clk), .reset(reset), .scroll_x(scroll_x), .pix_x(pix_x), .pix_y(pix_y),
        .video_active(video_active), .frame_start(frame_start),
        .player_x(player_x), .player_y(player_y),
        .car_on(car_on), .lane_idx(lane_idx), .hit(hit), .hit_count(hit_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Returns 0 for no car, lane+1 for a car pixel.
    function automatic int car_model(int px, int py, int va, int sq);
        int rel, lane, roff, eff;
        if (va == 0 || py < 96 || py >= 96 + 4 * 48) return 0;
        rel  = py - 96;
        lane = rel / 48;
        roff = rel % 48;
        if (roff < 8 || roff > 39) return 0;
        if (lane % 2 == 0) eff = (px + 640 - sq + lane * 40) % 640;
        else               eff = (px + sq + lane * 40) % 640;
        return (eff % 128 < 48) ? lane + 1 : 0;
    endfunction

    function automatic bit in_player(int px, int py);
        return px >= ply_x && px < ply_x + 32 && py >= ply_y && py < ply_y + 32;
    endfunction

    task automatic set_player(input int x, input int y);
        ply_x = x; ply_y = y;
        player_x = 10'(x); player_y = 10'(y);
    endtask

    task automatic drive(input int px, input int py, input int va, input int fs, input int sx);
        int m;
        bit ov;
        pix_x = 10'(px); pix_y = 10'(py); video_active = va[0];
        frame_start = fs[0]; scroll_x = 10'(sx);
        m  = car_model(px, py, va, msq);
        ov = (m != 0) && in_player(px, py);
        @(posedge clk);
        if (fs != 0) begin
            if (started) begin
                exp_hit = facc;
                if (CNT_EN && facc && exp_cnt < 255) exp_cnt++;
            end
            started = 1'b1;
            facc    = 1'b0;
            msq     = sx;
        end
        if (ov && started) facc = 1'b1;
        #1;
        check("car_on", int'(car_on), (pend != 0) ? 1 : 0);
        check("lane_idx", int'(lane_idx), (pend != 0) ? pend - 1 : 0);
        check("hit", int'(hit), exp_hit);
        check("hit_count", int'(hit_count), exp_cnt);
        pend = m;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            drive($urandom_range(0, 639), $urandom_range(0, 479), 0, 0, $urandom_range(0, 639));
    endtask

    // Drains the pipeline, then issues frame_start during blanking.
    task automatic frame(input int sx);
        idle(3);
        drive($urandom_range(0, 639), $urandom_range(0, 479), 0, 1, sx);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        msq     = 0;
        started = 1'b0;
        facc    = 1'b0;
        exp_hit = 0;
        exp_cnt = 0;
        pend    = 0;
        check("rst_car_on", int'(car_on), 0);
        check("rst_lane_idx", int'(lane_idx), 0);
        check("rst_hit", int'(hit), 0);
        check("rst_hit_count", int'(hit_count), 0);
    endtask

    initial begin
        reset = 1'b1;
        scroll_x = '0; pix_x = '0; pix_y = '0;
        video_active = 1'b0; frame_start = 1'b0;
        set_player(600, 0);
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // basic lane 0 car and gap
        frame(0);
        drive(10, 110, 1, 0, 0);
        drive(60, 110, 1, 0, 0);
        idle(2);

        // scroll latched only at frame_start
        frame(5);
        drive(50, 110, 1, 0, 5);
        drive(50, 110, 1, 0, 100);
        idle(2);

        // lane 1 phase and row inset
        frame(0);
        drive(0, 160, 1, 0, 0);
        drive(10, 160, 1, 0, 0);
        drive(0, 150, 1, 0, 0);
        idle(2);

        // wrap and blanked car pixel over the player
        set_player(0, 104);
        frame(639);
        drive(0, 110, 1, 0, 639);
        drive(2, 110, 0, 0, 639);
        frame(0);
        frame(0);

        // collision then no collision
        frame(0);
        drive(10, 110, 1, 0, 0);
        frame(0);
        set_player(0, 0);
        drive(10, 110, 1, 0, 0);
        drive(5, 5, 1, 0, 0);
        frame(0);
        frame(0);

        // saturation
        set_player(0, 104);
        for (int f = 0; f < 300; f++) begin
            frame(0);
            drive(10, 110, 1, 0, 0);
        end
        frame(0);

        // reset mid-frame; the next frame_start commits nothing
        drive(10, 110, 1, 0, 0);
        drive(12, 112, 1, 0, 0);
        do_reset();
        drive(10, 110, 1, 0, 0);
        frame(0);
        drive(10, 110, 1, 0, 0);
        frame(0);
        frame(0);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            set_player($urandom_range(0, 639), $urandom_range(80, 290));
            frame($urandom_range(0, 639));
            for (int p = 0; p < 400; p++) begin
                int px, py;
                if ($urandom_range(0, 3) == 0) begin
                    px = ply_x + $urandom_range(0, 31);
                    py = ply_y + $urandom_range(0, 31);
                    if (px > 639) px = 639;
                end else begin
                    px = $urandom_range(0, 639);
                    py = ($urandom_range(0, 9) < 7) ? $urandom_range(96, 287) : $urandom_range(0, 479);
                end
                drive(px, py, ($urandom_range(0, 7) != 0) ? 1 : 0, 0, $urandom_range(0, 639));
            end
        end
        frame(0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
